// File: rtl/prog_memory.sv
// Small program store with a phase-driven fetch/advance sequencer.
// Words are {operand, opcode}; the program is loaded in LOAD and replayed in EXEC.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_LOAD | memory writable through WE/WADDR/WDATA; P and JMP ignored
//   ST_EXEC | memory read-only; P selects fetch opcode/operand or PC advance

module prog_memory #(
    parameter int OP_W   = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [1:0]             P,
    input  logic                   WE,
    input  logic [ADDR_W-1:0]      WADDR,
    input  logic [OP_W+DATA_W-1:0] WDATA,
    input  logic                   RUN,
    input  logic                   JMP,
    input  logic [ADDR_W-1:0]      JADDR,
    output logic [OP_W-1:0]        INSTR,
    output logic [DATA_W-1:0]      DATA,
    output logic [ADDR_W-1:0]      PC,
    output logic                   IVALID,
    output logic                   DVALID,
    output logic                   WRAP
);

    localparam int                WORD_W  = OP_W + DATA_W;
    localparam logic [1:0]        PH_OP   = 2'd0;
    localparam logic [1:0]        PH_DATA = 2'd1;
    localparam logic [1:0]        PH_ADV  = 2'd3;
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_LOAD,
        ST_EXEC
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] cur_word;
    logic              in_exec;
    logic              load_wr;

    assign in_exec  = (state_q == ST_EXEC);
    assign load_wr  = (state_q == ST_LOAD) && WE;
    assign cur_word = mem[PC];

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Leaving EXEC only at the advance phase keeps a fetch pair from being split.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD: begin
                if (RUN) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if ((P == PH_ADV) && !RUN) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load_wr) begin
            mem[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            PC     <= '0;
            INSTR  <= '0;
            DATA   <= '0;
            IVALID <= 1'b0;
            DVALID <= 1'b0;
            WRAP   <= 1'b0;
        end else begin
            IVALID <= 1'b0;
            DVALID <= 1'b0;
            WRAP   <= 1'b0;
            if (in_exec) begin
                case (P)
                    PH_OP: begin
                        INSTR  <= cur_word[OP_W-1:0];
                        IVALID <= 1'b1;
                    end
                    PH_DATA: begin
                        DATA   <= cur_word[WORD_W-1:OP_W];
                        DVALID <= 1'b1;
                    end
                    PH_ADV: begin
                        // A taken branch never counts as a wrap, even to address 0.
                        if (JMP) begin
                            PC <= JADDR;
                        end else begin
                            PC   <= PC + 1'b1;
                            WRAP <= (PC == PC_LAST);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_memory.sv
// Scoreboard bench for prog_memory: a behavioural model queues expected fetches
// as each cycle is driven; they are popped and compared when the valid pulses appear.

module tb_prog_memory;

    localparam int OP_W   = 4;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int WORD_W = OP_W + DATA_W;

    logic              CLK;
    logic              RSTN;
    logic [1:0]        P;
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [WORD_W-1:0] WDATA;
    logic              RUN;
    logic              JMP;
    logic [ADDR_W-1:0] JADDR;
    logic [OP_W-1:0]   INSTR;
    logic [DATA_W-1:0] DATA;
    logic [ADDR_W-1:0] PC;
    logic              IVALID;
    logic              DVALID;
    logic              WRAP;

    prog_memory #(
        .OP_W   (OP_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .P      (P),
        .WE     (WE),
        .WADDR  (WADDR),
        .WDATA  (WDATA),
        .RUN    (RUN),
        .JMP    (JMP),
        .JADDR  (JADDR),
        .INSTR  (INSTR),
        .DATA   (DATA),
        .PC     (PC),
        .IVALID (IVALID),
        .DVALID (DVALID),
        .WRAP   (WRAP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    logic [WORD_W-1:0] m_mem [DEPTH];
    logic              m_exec;
    logic [ADDR_W-1:0] m_pc;
    logic [OP_W-1:0]   m_instr;
    logic [DATA_W-1:0] m_data;
    logic              m_iv;
    logic              m_dv;
    logic              m_wrap;

    logic [OP_W-1:0]   q_instr [$];
    logic [DATA_W-1:0] q_data  [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [WORD_W-1:0] w;
        m_iv   = 1'b0;
        m_dv   = 1'b0;
        m_wrap = 1'b0;
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_exec  = 1'b0;
            m_pc    = '0;
            m_instr = '0;
            m_data  = '0;
        end else if (!m_exec) begin
            if (WE) m_mem[WADDR] = WDATA;
            if (RUN) m_exec = 1'b1;
        end else begin
            w = m_mem[m_pc];
            if (P == 2'd0) begin
                m_instr = w[3:0];
                m_iv    = 1'b1;
                q_instr.push_back(w[3:0]);
            end else if (P == 2'd1) begin
                m_data = w[7:4];
                m_dv   = 1'b1;
                q_data.push_back(w[7:4]);
            end else if (P == 2'd3) begin
                if (JMP) begin
                    m_pc = JADDR;
                end else begin
                    m_wrap = (m_pc == 2'd3);
                    m_pc   = m_pc + 2'd1;
                end
                if (!RUN) m_exec = 1'b0;
            end
        end
    endtask

    task automatic cyc(input logic rstn, input logic run, input logic [1:0] p,
                       input logic we, input logic [ADDR_W-1:0] waddr,
                       input logic [WORD_W-1:0] wdata, input logic jmp,
                       input logic [ADDR_W-1:0] jaddr);
        RSTN  = rstn;
        RUN   = run;
        P     = p;
        WE    = we;
        WADDR = waddr;
        WDATA = wdata;
        JMP   = jmp;
        JADDR = jaddr;
        model_step();
        @(posedge CLK);
        #1;
        chk("ivalid", IVALID, m_iv);
        chk("dvalid", DVALID, m_dv);
        chk("wrap", WRAP, m_wrap);
        chk("pc", PC, m_pc);
        if ((IVALID || m_iv) && q_instr.size() > 0) chk("instr_fetch", INSTR, q_instr.pop_front());
        if ((DVALID || m_dv) && q_data.size() > 0) chk("data_fetch", DATA, q_data.pop_front());
        chk("instr_hold", INSTR, m_instr);
        chk("data_hold", DATA, m_data);
    endtask

    task automatic ld(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d, input logic run);
        cyc(1'b1, run, 2'd0, 1'b1, a, d, 1'b0, '0);
    endtask

    task automatic ph(input logic [1:0] p, input logic run, input logic jmp, input logic [ADDR_W-1:0] ja);
        cyc(1'b1, run, p, 1'b0, '0, '0, jmp, ja);
    endtask

    initial begin
        RSTN = 1'b0; RUN = 1'b0; P = 2'd0; WE = 1'b0;
        WADDR = '0; WDATA = '0; JMP = 1'b0; JADDR = '0;

        // reset
        cyc(1'b0, 1'b1, 2'd3, 1'b1, 2'd1, 8'h55, 1'b0, '0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, 1'b0, '0);

        // load; P/JMP ignored in LOAD, final write on the RUN edge still lands
        ld(2'd0, 8'hA1, 1'b0);
        cyc(1'b1, 1'b0, 2'd3, 1'b1, 2'd1, 8'hB2, 1'b1, 2'd2);
        ld(2'd2, 8'hC3, 1'b0);
        ld(2'd3, 8'hD4, 1'b1);

        // straight run over the whole program, wrap after last advance
        for (int k = 0; k < 4; k++) begin
            ph(2'd0, 1'b1, 1'b0, '0);
            ph(2'd1, 1'b1, 1'b0, '0);
            ph(2'd2, 1'b1, 1'b0, '0);
            ph(2'd3, 1'b1, 1'b0, '0);
        end

        // jump from 1 to 3, then jump 3 -> 0 without wrap
        ph(2'd3, 1'b1, 1'b0, '0);
        ph(2'd3, 1'b1, 1'b1, 2'd3);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd3, 1'b1, 1'b1, 2'd0);

        // write attempt during EXEC must be dropped
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 2'd0, 8'hFF, 1'b0, '0);

        // stop request outside P==3 is ignored; honoured at P==3
        ph(2'd1, 1'b0, 1'b0, '0);
        ph(2'd0, 1'b0, 1'b0, '0);
        ph(2'd3, 1'b0, 1'b0, '0);
        ph(2'd0, 1'b0, 1'b0, '0);
        ph(2'd3, 1'b0, 1'b0, '0);

        // back to EXEC, re-read word 0
        ph(2'd2, 1'b1, 1'b0, '0);
        ph(2'd3, 1'b1, 1'b1, 2'd0);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd1, 1'b1, 1'b0, '0);

        // repeated phases re-perform their action
        ph(2'd3, 1'b1, 1'b0, '0);
        ph(2'd3, 1'b1, 1'b0, '0);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd1, 1'b1, 1'b0, '0);
        ph(2'd1, 1'b1, 1'b0, '0);

        // reset in the middle of a run with PC=2, then run with an empty program
        ph(2'd3, 1'b1, 1'b1, 2'd2);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 2'd2, 8'h77, 1'b0, '0);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd0, 1'b1, 1'b0, '0);
        ph(2'd1, 1'b1, 1'b0, '0);
        ph(2'd3, 1'b1, 1'b0, '0);

        // reload a fresh program and exercise random traffic
        ph(2'd3, 1'b0, 1'b0, '0);
        for (int a = 0; a < DEPTH; a++) ld(ADDR_W'(a), WORD_W'($urandom_range(0, 255)), 1'b0);
        for (int n = 0; n < 300; n++) begin
            cyc(($urandom_range(0, 39) != 0),
                ($urandom_range(0, 5) != 0),
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                ADDR_W'($urandom_range(0, DEPTH - 1)),
                WORD_W'($urandom_range(0, 255)),
                ($urandom_range(0, 3) == 0),
                ADDR_W'($urandom_range(0, DEPTH - 1)));
        end

        chk("instr_queue_drained", q_instr.size(), 0);
        chk("data_queue_drained", q_data.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 Parameter OP_W, default 4, opcode field width (low bits of each word).
REQ-002 Parameter DATA_W, default 4, operand field width (high bits of each word).
REQ-003 Parameter DEPTH, default 4, word count; power of two, >= 2.
REQ-004 Parameter ADDR_W, default $clog2(DEPTH), address width; derived, never overridden.
REQ-005 CLK  in  1  single clock; all state updates on posedge.
REQ-006 RSTN  in  1  reset, synchronous, active-low.
REQ-007 P  in  2  phase: 0 fetch opcode, 1 fetch operand, 2 execute, 3 advance.
REQ-008 WE  in  1  program-load write strobe.
REQ-009 WADDR  in  ADDR_W  write address.
REQ-010 WDATA  in  OP_W+DATA_W  write word, {operand, opcode}.
REQ-011 RUN  in  1  level; 1 = execute program, 0 = return to load.
REQ-012 JMP  in  1  level, sampled at P==3; take branch.
REQ-013 JADDR  in  ADDR_W  branch target.
REQ-014 INSTR  out  OP_W  registered opcode to control unit.
REQ-015 DATA  out  DATA_W  registered operand to internal bus.
REQ-016 PC  out  ADDR_W  current program counter.
REQ-017 IVALID  out  1  one-cycle pulse, INSTR updated.
REQ-018 DVALID  out  1  one-cycle pulse, DATA updated.
REQ-019 WRAP  out  1  one-cycle pulse, PC wrapped DEPTH-1 -> 0.

Function
REQ-020 Storage SHALL be DEPTH words of OP_W+DATA_W bits, written synchronously only.
REQ-021 FSM SHALL have two states: LOAD, EXEC.
REQ-022 LOAD: WE=1 SHALL write WDATA to mem[WADDR] on that edge; P, JMP ignored; outputs hold.
REQ-023 LOAD -> EXEC SHALL occur on the edge where RUN=1; a WE on that same edge is still written.
REQ-024 EXEC: WE SHALL be ignored (memory read-only).
REQ-025 EXEC, P==0: INSTR <= mem[PC][OP_W-1:0], IVALID=1 next cycle only.
REQ-026 EXEC, P==1: DATA <= mem[PC][OP_W+DATA_W-1:OP_W], DVALID=1 next cycle only.
REQ-027 EXEC, P==2: no state change.
REQ-028 EXEC, P==3: PC <= JMP ? JADDR : PC+1, modulo DEPTH.
REQ-029 Non-jump advance from PC=DEPTH-1 SHALL give PC=0 and WRAP=1 next cycle; a jump SHALL never assert WRAP, even when JADDR=0.
REQ-030 EXEC -> LOAD SHALL occur only at a P==3 edge with RUN=0; the PC advance on that edge still happens. RUN=0 in other phases SHALL be ignored until P==3.
REQ-031 Phase sequence SHALL NOT be checked; a repeated phase value re-performs its action, including repeated PC advance.
REQ-032 Fetch latency SHALL be one cycle: output valid on the edge after the phase sample.
REQ-033 IVALID, DVALID and WRAP SHALL be low in every cycle not listed above.

Reset
REQ-034 RSTN=0 at a posedge SHALL set state=LOAD, PC=0, INSTR=0, DATA=0, IVALID=0, DVALID=0, WRAP=0, all memory words=0.
REQ-035 Reset SHALL take priority over WE, RUN and P on the same edge, including mid-EXEC; memory is cleared.
REQ-036 Release with RSTN=1 SHALL resume normal operation on the next edge.

Verification
REQ-037 Load: reset, write 0xA1, 0xB2, 0xC3, 0xD4 to addresses 0-3, RUN=1, cycle P 0,1,2,3 x4 -> INSTR 1,2,3,4; DATA A,B,C,D; IVALID and DVALID each pulse once per word; PC 0,1,2,3,0; WRAP pulses once after the 4th P==3.
REQ-038 Jump: at PC=1, P==3 with JMP=1, JADDR=3 -> PC=3, WRAP=0; next P==0 -> INSTR=4.
REQ-039 Jump to 0: at PC=3, JMP=1, JADDR=0 -> PC=0, WRAP stays 0.
REQ-040 Write-protect: in EXEC, WE=1, WADDR=0, WDATA=0xFF; then return to LOAD and read via EXEC -> mem[0] still 0xA1.
REQ-041 Stop: RUN=0 at P==1 -> remains EXEC, DATA fetched; at P==3 -> PC advances, state LOAD; later P==0 -> INSTR unchanged, IVALID=0.
REQ-042 Reset mid-run: RSTN=0 at P==1, PC=2 -> next cycle PC=0, INSTR=0, DATA=0, state LOAD; RUN=1 with no loads -> INSTR=0, DATA=0.
